// File: rtl/complex_fix_mul_pipe.sv
// ---------------------------------------------------------------------------
// complex_fix_mul_pipe
//
// Pipelined, handshaked complex fixed-point multiplier computing
// out = x * y, or x * conj(y) when conj_y is set for that beat.
// Three register stages:
//   S1 - captured operands, with the imaginary part of y optionally negated
//   S2 - four full-precision partial products
//   S3 - combined, rounded and saturated result (the output register)
//
// Handshake: a beat moves on the input port when in_valid & in_ready, and on
// the output port when out_valid & out_ready. out_valid, out and out_sat are
// held stable while out_valid=1 and out_ready=0. in_ready does not depend on
// in_valid, and out_valid does not depend on out_ready.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  input handshake
//   x[0:1], y[0:1]      signed operands, [0]=real, [1]=imag
//   conj_y              per-beat: multiply by conj(y)
//   out_valid,out_ready output handshake
//   out[0:1]            signed result, [0]=real, [1]=imag
//   out_sat             current output beat clipped in either component
//   sat_sticky          OR of out_sat over consumed beats since reset/clear
//   sat_clear           synchronous clear of sat_sticky, wins over a set
// ---------------------------------------------------------------------------
module complex_fix_mul_pipe #(
   parameter int IN_BITS  = 16,
   parameter int IN_FRAC  = 14,
   parameter int OUT_BITS = 18,
   parameter int OUT_FRAC = 14,
   parameter int ROUND    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [IN_BITS-1:0]  x [0:1],
   input  logic signed [IN_BITS-1:0]  y [0:1],
   input  logic                       conj_y,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OUT_BITS-1:0] out [0:1],
   output logic                       out_sat,
   output logic                       sat_sticky,
   input  logic                       sat_clear
);

   // Product width, sum width, and the sum width with one bit of headroom
   // for the rounding increment.
   localparam int PW  = 2*IN_BITS + 1;
   localparam int SW  = 2*IN_BITS + 2;
   localparam int RW  = SW + 1;
   localparam int SH  = 2*IN_FRAC - OUT_FRAC;
   localparam int RSH = (SH > 0) ? SH - 1 : 0;

   localparam logic signed [RW-1:0] RND_INC =
      (ROUND != 0 && SH > 0) ? (RW'(1) << RSH) : '0;
   localparam logic signed [RW-1:0] OMAX =
      {{(RW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = ~OMAX;

   // Global advance: every stage moves together unless the output is full
   // and not being consumed. Bubbles travel with the pipe.
   logic adv;
   logic v1, v2, v3;

   assign adv       = ~v3 | out_ready;
   assign in_ready  = adv;
   assign out_valid = v3;

   // ---------------- S1: operand capture ----------------
   logic signed [IN_BITS-1:0] s1_a, s1_b, s1_c;
   logic signed [IN_BITS:0]   s1_d;
   logic signed [IN_BITS:0]   d_ext, d_in;

   // One extra bit so that negating the most negative value cannot overflow.
   always_comb begin
      d_ext = {y[1][IN_BITS-1], y[1]};
      d_in  = conj_y ? -d_ext : d_ext;
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_a <= x[0];
         s1_b <= x[1];
         s1_c <= y[0];
         s1_d <= d_in;
      end
   end

   // ---------------- S2: partial products ----------------
   logic signed [PW-1:0] s2_ac, s2_bd, s2_bc, s2_ad;

   always_ff @(posedge clk) begin
      if (adv) begin
         s2_ac <= PW'(s1_a) * PW'(s1_c);
         s2_bd <= PW'(s1_b) * PW'(s1_d);
         s2_bc <= PW'(s1_b) * PW'(s1_c);
         s2_ad <= PW'(s1_a) * PW'(s1_d);
      end
   end

   // ---------------- S3: combine, round, saturate ----------------
   logic signed [SW-1:0]       sum_re, sum_im;
   logic signed [OUT_BITS-1:0] res_re, res_im;
   logic                       sat_re, sat_im;

   // Returns {clipped, value}. Right shift is arithmetic, so ROUND=0 floors.
   function automatic logic [OUT_BITS:0] round_sat(input logic signed [SW-1:0] v);
      logic signed [RW-1:0] t;
      t = RW'(v) + RND_INC;
      t = t >>> SH;
      if (t > OMAX)      round_sat = {1'b1, OMAX[OUT_BITS-1:0]};
      else if (t < OMIN) round_sat = {1'b1, OMIN[OUT_BITS-1:0]};
      else               round_sat = {1'b0, t[OUT_BITS-1:0]};
   endfunction

   always_comb begin
      sum_re = SW'(s2_ac) - SW'(s2_bd);
      sum_im = SW'(s2_ad) + SW'(s2_bc);
      {sat_re, res_re} = round_sat(sum_re);
      {sat_im, res_im} = round_sat(sum_im);
   end

   // Output data only updates when a real beat lands, so out keeps its last
   // value across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         out[0]  <= '0;
         out[1]  <= '0;
         out_sat <= 1'b0;
      end else if (adv) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
         if (v2) begin
            out[0]  <= res_re;
            out[1]  <= res_im;
            out_sat <= sat_re | sat_im;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             sat_sticky <= 1'b0;
      else if (sat_clear)                     sat_sticky <= 1'b0;
      else if (v3 && out_ready && out_sat)    sat_sticky <= 1'b1;
   end

endmodule

// File: tb/tb_complex_fix_mul_pipe.sv
// Self-checking bench for complex_fix_mul_pipe (default parameters, 1.0 = 16384).
// A second instance with ROUND=0 shares the input stimulus for the truncation case.
module tb_complex_fix_mul_pipe;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid, in_ready, in_ready_t;
   logic signed [15:0] x [0:1];
   logic signed [15:0] y [0:1];
   logic conj_y;
   logic out_valid, out_valid_t, out_ready;
   logic signed [17:0] out [0:1];
   logic signed [17:0] out_t [0:1];
   logic out_sat, out_sat_t, sat_sticky, sat_sticky_t, sat_clear;

   int checks   = 0;
   int failures = 0;

   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   complex_fix_mul_pipe u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .conj_y(conj_y), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_sat(out_sat), .sat_sticky(sat_sticky), .sat_clear(sat_clear)
   );

   complex_fix_mul_pipe #(.ROUND(0)) u_dut_t (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
      .x(x), .y(y), .conj_y(conj_y), .out_valid(out_valid_t), .out_ready(out_ready),
      .out(out_t), .out_sat(out_sat_t), .sat_sticky(sat_sticky_t), .sat_clear(sat_clear)
   );

   task automatic check_val(input string tag, input logic signed [39:0] act,
                            input logic signed [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic set_in(input int xr, input int xi, input int yr, input int yi,
                         input logic cj);
      x[0] = 16'(xr); x[1] = 16'(xi);
      y[0] = 16'(yr); y[1] = 16'(yi);
      conj_y = cj;
   endtask

   // One beat into an idle pipe; returns 1 cycle after the accepting edge.
   task automatic send_beat(input int xr, input int xi, input int yr, input int yi,
                            input logic cj);
      @(posedge clk); #1;
      set_in(xr, xi, yr, yi, cj);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts cycles from the accept cycle until out_valid, bounded.
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Reference: exact complex product, round half up at 2^13, floor shift, clip.
   function automatic logic [36:0] model(input int xr, input int xi, input int yr,
                                         input int yi, input logic cj);
      longint dd, re, im;
      logic sat;
      logic [17:0] rr, ri;
      dd  = cj ? -longint'(yi) : longint'(yi);
      re  = longint'(xr) * yr - longint'(xi) * dd;
      im  = longint'(xr) * dd + longint'(xi) * yr;
      re  = (re + 8192) >>> 14;
      im  = (im + 8192) >>> 14;
      sat = 1'b0;
      if (re > 131071)  begin re = 131071;  sat = 1'b1; end
      if (re < -131072) begin re = -131072; sat = 1'b1; end
      if (im > 131071)  begin im = 131071;  sat = 1'b1; end
      if (im < -131072) begin im = -131072; sat = 1'b1; end
      rr = 18'(re);
      ri = 18'(im);
      return {sat, rr, ri};
   endfunction

   initial begin
      int lat;
      int idx, got, nout;
      bit saw_block;
      logic [36:0] e;
      int vx [0:7][0:3];
      logic vc [0:7];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clear = 1'b0;
      set_in(0, 0, 0, 0, 1'b0);

      // Reset state
      #3;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_re", out[0], 0);
      check_val("rst_out_im", out[1], 0);
      check_val("rst_out_sat", out_sat, 0);
      check_val("rst_sticky", sat_sticky, 0);
      #14 rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("rst_in_ready", in_ready, 1);

      // 1: 1.0 * i = i, latency 3
      send_beat(16384, 0, 0, 16384, 1'b0);
      wait_out(lat);
      check_val("t1_latency", lat, 3);
      check_val("t1_re", out[0], 0);
      check_val("t1_im", out[1], 16384);
      check_val("t1_sat", out_sat, 0);

      // 2: i * conj(i) = 1, i * i = -1
      send_beat(0, 16384, 0, 16384, 1'b1);
      wait_out(lat);
      check_val("t2_conj_re", out[0], 16384);
      check_val("t2_conj_im", out[1], 0);
      send_beat(0, 16384, 0, 16384, 1'b0);
      wait_out(lat);
      check_val("t2_re", out[0], -16384);
      check_val("t2_im", out[1], 0);

      // 3: (-2-2i)^2 = 8i -> clipped imag, sticky, clear
      send_beat(-32768, -32768, -32768, -32768, 1'b0);
      wait_out(lat);
      check_val("t3_re", out[0], 0);
      check_val("t3_im", out[1], 131071);
      check_val("t3_sat", out_sat, 1);
      @(posedge clk); #1;
      check_val("t3_sticky_set", sat_sticky, 1);
      sat_clear = 1'b1;
      @(posedge clk); #1;
      sat_clear = 1'b0;
      check_val("t3_sticky_clr", sat_sticky, 0);

      // 4: rounding at the half-LSB boundary
      send_beat(1, 0, 8192, 0, 1'b0);
      wait_out(lat);
      check_val("t4_rnd_re", out[0], 1);
      check_val("t4_rnd_im", out[1], 0);
      check_val("t4_trn_valid", out_valid_t, 1);
      check_val("t4_trn_re", out_t[0], 0);
      check_val("t4_trn_im", out_t[1], 0);
      send_beat(-1, 0, 8192, 0, 1'b0);
      wait_out(lat);
      check_val("t4_neg_rnd_re", out[0], 0);
      check_val("t4_neg_trn_re", out_t[0], -1);

      // 5: 8 random beats with a 5-cycle output stall mid-stream
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 4; k++) vx[i][k] = int'($signed(16'($urandom_range(0, 65535))));
         vc[i] = 1'($urandom_range(0, 1));
      end
      vx[5][0] = -32768; vx[5][1] = -32768; vx[5][2] = -32768; vx[5][3] = -32768; vc[5] = 1'b0;
      idx = 0; got = 0; saw_block = 1'b0;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         @(posedge clk); #1;
         out_ready = (cyc >= 3 && cyc < 8) ? 1'b0 : 1'b1;
         if (idx < 8) begin
            set_in(vx[idx][0], vx[idx][1], vx[idx][2], vx[idx][3], vc[idx]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (in_valid && !in_ready) saw_block = 1'b1;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(vx[idx][0], vx[idx][1], vx[idx][2], vx[idx][3], vc[idx]));
            idx++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_val("s_unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_val("s_re", out[0], $signed(e[35:18]));
               check_val("s_im", out[1], $signed(e[17:0]));
               check_val("s_sat", out_sat, e[36]);
            end
            got++;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      check_val("s_beats_out", got, 8);
      check_val("s_in_blocked", saw_block, 1);
      check_val("s_queue_empty", exp_q.size(), 0);

      // 6: reset with 3 beats in flight
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         set_in(16384, 0, 16384, 0, 1'b0);
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check_val("r_pre_valid", out_valid, 1);
      check_val("r_pre_re", out[0], 16384);
      rst_n = 1'b0;
      #1;
      check_val("r_valid_drop", out_valid, 0);
      check_val("r_out_re", out[0], 0);
      check_val("r_out_im", out[1], 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_val("r_in_ready", in_ready, 1);
      nout = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) nout++;
      end
      check_val("r_no_stale", nout, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
